change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles allowed for one coin handshake.
REQ-002 The block SHALL have parameter CW, default 4, meaning the width of credit, price, change and stock counts, in 5-cent units.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to dispense change for the current credit and price.
REQ-006 credit  input  CW  money inserted, in nickels (e.g. 3 = 15c).
REQ-007 price  input  CW  item price, in nickels.
REQ-008 load_stock  input  1  load the hopper inventory counters.
REQ-009 dime_in, nickel_in  input  CW each  inventory values used by load_stock.
REQ-010 hop_ack  input  1  coin hopper acknowledge (4-phase).
REQ-011 hop_dime, hop_nickel  output  1 each  coin eject requests, level, at most one high.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when all change has been paid.
REQ-014 fault  output  1  one-cycle pulse on abort; fault_code  output  2  01 underpay, 10 stock short, 11 timeout, held until the next start.
REQ-015 dime_stock, nickel_stock  output  CW each  current inventory.

Function
REQ-016 The FSM SHALL have states IDLE, CALC, REQ, WAIT_LOW and END.
REQ-017 In IDLE, load_stock SHALL copy dime_in and nickel_in into the stock counters, and a start in the same cycle SHALL be ignored.
REQ-018 In IDLE, start without load_stock SHALL latch credit and price, clear fault_code, and go to CALC; start outside IDLE, and load_stock outside IDLE, SHALL be ignored.
REQ-019 CALC SHALL compute c = credit - price (CW-bit unsigned), with price > credit giving fault code 01 and a return to IDLE.
REQ-020 CALC SHALL plan d = min(dime_stock, c/2) dimes and n = c - 2d nickels.
REQ-021 If n > nickel_stock, CALC SHALL give fault code 10 and return to IDLE with nothing dispensed and stock unchanged.
REQ-022 If c = 0, CALC SHALL go to END; otherwise it SHALL go to REQ.
REQ-023 The first request SHALL assert 2 cycles after the start cycle, and done SHALL pulse 2 cycles after start when c = 0.
REQ-024 REQ SHALL drive hop_dime while dimes remain, else hop_nickel; dimes always go first.
REQ-025 In REQ, hop_ack = 1 SHALL, on the same edge, drop the request, decrement the matching stock counter and remaining count, and enter WAIT_LOW.
REQ-026 In WAIT_LOW, hop_ack = 0 SHALL go to REQ if coins remain, else to END.
REQ-027 END SHALL pulse done for one cycle and return to IDLE.
REQ-028 A handshake timer SHALL clear on entry to REQ and count cycles in REQ and WAIT_LOW; reaching TIMEOUT SHALL drop both requests, give fault code 11, and return to IDLE.
REQ-029 After a timeout, stock SHALL reflect only acknowledged coins.
REQ-030 Stock counters SHALL never wrap, and underflow SHALL be impossible by construction (plan checked in CALC).
REQ-031 An abort SHALL pulse fault for one cycle in the cycle the FSM re-enters IDLE.

Reset
REQ-032 Reset SHALL immediately force IDLE, hop_dime = hop_nickel = 0, busy = done = fault = 0, fault_code = 00, both stock counters 0, and the timer to 0, including mid-handshake.

Structure
REQ-033 Package change_pkg SHALL hold the state enum, the fault code constants (FC_NONE, FC_UNDERPAY, FC_STOCK, FC_TIMEOUT) and default CW.
REQ-034 The timeout counter SHALL be sub-module change_hs_timer (inputs clear and enable; output expired; parameter TIMEOUT); everything else is in change_dispenser.

Verification
REQ-035 load 5 dimes and 5 nickels, then credit = 6, price = 1 -> 2 dime handshakes then 1 nickel handshake, done pulse, stock ends at 3 dimes and 4 nickels.
REQ-036 dime stock 0, nickel stock 3, credit = 4, price = 0 -> fault, fault_code = 10, no request asserted, stock unchanged.
REQ-037 credit = 2, price = 3 -> fault code 01 two cycles after start; credit = price = 5 -> done two cycles after start with no request.
REQ-038 hop_ack held low with TIMEOUT = 8 -> hop_dime high 8 cycles then low, fault code 11, stock unchanged; ack stuck high in WAIT_LOW -> same fault code 11.
REQ-039 reset asserted while hop_nickel is high -> request low with no clock edge, stock = 0, busy = 0; start issued mid-dispense and load_stock issued while busy -> both ignored.

Source files
------------

// File: rtl/change_pkg.sv
// rtl/change_pkg.sv - shared types and constants for the change dispenser
package change_pkg;

    localparam int CW_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        REQ,
        WAIT_LOW,
        END
    } state_t;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_UNDERPAY = 2'b01;
    localparam logic [1:0] FC_STOCK    = 2'b10;
    localparam logic [1:0] FC_TIMEOUT  = 2'b11;

endpackage

// File: rtl/change_hs_timer.sv
// rtl/change_hs_timer.sv - per-coin handshake watchdog
module change_hs_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] count;

    // expired flags the last counted cycle, so the FSM leaves on the TIMEOUT-th edge
    assign expired = enable && (count == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - pays out change in dimes then nickels via a 4-phase hopper
module change_dispenser
    import change_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] credit,
    input  logic [CW-1:0] price,
    input  logic          load_stock,
    input  logic [CW-1:0] dime_in,
    input  logic [CW-1:0] nickel_in,
    input  logic          hop_ack,
    output logic          hop_dime,
    output logic          hop_nickel,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [1:0]    fault_code,
    output logic [CW-1:0] dime_stock,
    output logic [CW-1:0] nickel_stock
);

    state_t        state, state_next;
    logic [CW-1:0] credit_r, price_r;
    logic [CW-1:0] dimes_left, nickels_left;
    logic [CW-1:0] change, half, plan_d, plan_n;
    logic          underpay, stock_short;
    logic          abort;
    logic [1:0]    abort_code;
    logic          expired, timer_clear, timer_enable;
    logic          accept_start, take_coin;

    assign change      = credit_r - price_r;
    assign underpay    = price_r > credit_r;
    assign half        = change >> 1;
    assign plan_d      = (dime_stock < half) ? dime_stock : half;
    assign plan_n      = change - (plan_d << 1);
    assign stock_short = plan_n > nickel_stock;

    assign accept_start = (state == IDLE) && start && !load_stock;
    assign take_coin    = (state == REQ) && hop_ack && !expired;

    assign hop_dime   = (state == REQ) && (dimes_left != '0);
    assign hop_nickel = (state == REQ) && (dimes_left == '0);
    assign busy       = (state != IDLE);
    assign done       = (state == END);

    assign timer_enable = (state == REQ) || (state == WAIT_LOW);
    assign timer_clear  = (state_next == REQ) && (state != REQ);

    change_hs_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        abort_code = FC_NONE;
        case (state)
            IDLE: begin
                if (accept_start) state_next = CALC;
            end
            CALC: begin
                if (underpay) begin
                    abort      = 1'b1;
                    abort_code = FC_UNDERPAY;
                    state_next = IDLE;
                end else if (stock_short) begin
                    abort      = 1'b1;
                    abort_code = FC_STOCK;
                    state_next = IDLE;
                end else if (change == '0) begin
                    state_next = END;
                end else begin
                    state_next = REQ;
                end
            end
            REQ, WAIT_LOW: begin
                if (expired) begin
                    abort      = 1'b1;
                    abort_code = FC_TIMEOUT;
                    state_next = IDLE;
                end else if (state == REQ && hop_ack) begin
                    state_next = WAIT_LOW;
                end else if (state == WAIT_LOW && !hop_ack) begin
                    state_next = (dimes_left != '0 || nickels_left != '0) ? REQ : END;
                end
            end
            END:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_r     <= '0;
            price_r      <= '0;
            dimes_left   <= '0;
            nickels_left <= '0;
            dime_stock   <= '0;
            nickel_stock <= '0;
            fault        <= 1'b0;
            fault_code   <= FC_NONE;
        end else begin
            fault <= abort;
            if (state == IDLE && load_stock) begin
                dime_stock   <= dime_in;
                nickel_stock <= nickel_in;
            end
            if (accept_start) begin
                credit_r   <= credit;
                price_r    <= price;
                fault_code <= FC_NONE;
            end
            if (abort) fault_code <= abort_code;
            if (state == CALC) begin
                dimes_left   <= plan_d;
                nickels_left <= plan_n;
            end
            // the plan was checked against stock in CALC, so these never underflow
            if (take_coin) begin
                if (dimes_left != '0) begin
                    dimes_left <= dimes_left - CW'(1);
                    dime_stock <= dime_stock - CW'(1);
                end else begin
                    nickels_left <= nickels_left - CW'(1);
                    nickel_stock <= nickel_stock - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - randomized self-checking bench for change_dispenser
module tb_change_dispenser;

    localparam int CW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset, start, load_stock, hop_ack;
    logic [CW-1:0] credit, price, dime_in, nickel_in;
    logic          hop_dime, hop_nickel, busy, done, fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] dime_stock, nickel_stock;

    int checks = 0;
    int errors = 0;
    int md = 0;
    int mn = 0;

    change_dispenser #(.TIMEOUT(TO), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .credit       (credit),
        .price        (price),
        .load_stock   (load_stock),
        .dime_in      (dime_in),
        .nickel_in    (nickel_in),
        .hop_ack      (hop_ack),
        .hop_dime     (hop_dime),
        .hop_nickel   (hop_nickel),
        .busy         (busy),
        .done         (done),
        .fault        (fault),
        .fault_code   (fault_code),
        .dime_stock   (dime_stock),
        .nickel_stock (nickel_stock)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_stock(input string tag);
        check({tag, "_dstock"}, 32'(dime_stock), md);
        check({tag, "_nstock"}, 32'(nickel_stock), mn);
    endtask

    task automatic do_load(input int d, input int n);
        load_stock = 1'b1;
        dime_in    = CW'(d);
        nickel_in  = CW'(n);
        tick();
        load_stock = 1'b0;
        md = d;
        mn = n;
        check_stock("load");
    endtask

    // mode_sel: 0 normal, 1 first coin never acked, 2 first coin ack stuck high, 3 random mix
    task automatic run_txn(input int cr, input int pr, input bit poke, input int mode_sel);
        int  c, d, n, k, m, mode;
        bit  isd;
        credit = CW'(cr);
        price  = CW'(pr);
        start  = 1'b1;
        tick();
        start = 1'b0;
        check("calc_busy", 32'(busy), 1);
        tick();
        if (pr > cr) begin
            check("under_fault", 32'(fault), 1);
            check("under_code", 32'(fault_code), 1);
            check("under_busy", 32'(busy), 0);
            check_stock("under");
            return;
        end
        c = cr - pr;
        d = (md < c / 2) ? md : c / 2;
        n = c - 2 * d;
        if (n > mn) begin
            check("short_fault", 32'(fault), 1);
            check("short_code", 32'(fault_code), 2);
            check("short_req", 32'(hop_dime | hop_nickel), 0);
            check("short_busy", 32'(busy), 0);
            check_stock("short");
            return;
        end
        if (c == 0) begin
            check("zero_done", 32'(done), 1);
            check("zero_req", 32'(hop_dime | hop_nickel), 0);
            check("zero_code", 32'(fault_code), 0);
            tick();
            check("zero_done_off", 32'(done), 0);
            check("zero_idle", 32'(busy), 0);
            return;
        end
        for (int i = 0; i < d + n; i++) begin
            isd = (i < d);
            if (mode_sel == 3) begin
                k = $urandom_range(0, 9);
                mode = (k == 0) ? 1 : (k == 1) ? 2 : 0;
            end else begin
                mode = (i == 0) ? mode_sel : 0;
            end
            check("req_dime", 32'(hop_dime), 32'(isd));
            check("req_nickel", 32'(hop_nickel), 32'(!isd));
            if (mode == 1) begin
                for (int j = 1; j < TO; j++) begin
                    tick();
                    check("to_req_held", 32'(hop_dime | hop_nickel), 1);
                end
                tick();
                check("to_req_drop", 32'(hop_dime | hop_nickel), 0);
                check("to_fault", 32'(fault), 1);
                check("to_code", 32'(fault_code), 3);
                check("to_busy", 32'(busy), 0);
                check_stock("to");
                return;
            end
            k = (poke && i == 0) ? 2 : $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                if (poke && i == 0 && j == 0) begin
                    start      = 1'b1;
                    load_stock = 1'b1;
                    dime_in    = '1;
                    nickel_in  = '1;
                    credit     = '0;
                    price      = '0;
                end
                tick();
                start      = 1'b0;
                load_stock = 1'b0;
                check("wait_req_held", 32'(isd ? hop_dime : hop_nickel), 1);
            end
            hop_ack = 1'b1;
            tick();
            if (isd) md--; else mn--;
            check("ack_req_drop", 32'(hop_dime | hop_nickel), 0);
            check_stock("ack");
            if (mode == 2) begin
                for (int j = 0; j < 3 * TO && busy; j++) tick();
                check("stuck_busy", 32'(busy), 0);
                check("stuck_fault", 32'(fault), 1);
                check("stuck_code", 32'(fault_code), 3);
                hop_ack = 1'b0;
                check_stock("stuck");
                return;
            end
            m = $urandom_range(0, 2);
            repeat (m) tick();
            hop_ack = 1'b0;
            tick();
        end
        check("pay_done", 32'(done), 1);
        check("pay_code", 32'(fault_code), 0);
        check("pay_req", 32'(hop_dime | hop_nickel), 0);
        tick();
        check("pay_done_off", 32'(done), 0);
        check("pay_idle", 32'(busy), 0);
        check_stock("pay");
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        load_stock = 1'b0;
        hop_ack    = 1'b0;
        credit     = '0;
        price      = '0;
        dime_in    = '0;
        nickel_in  = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_code", 32'(fault_code), 0);
        check("rst_req", 32'(hop_dime | hop_nickel), 0);
        check_stock("rst");
        reset = 1'b0;
        tick();

        do_load(5, 5);
        run_txn(6, 1, 1'b0, 0);
        check("s035_d", 32'(dime_stock), 3);
        check("s035_n", 32'(nickel_stock), 4);

        do_load(0, 3);
        run_txn(4, 0, 1'b0, 0);
        run_txn(2, 3, 1'b0, 0);
        run_txn(5, 5, 1'b0, 0);

        do_load(5, 5);
        run_txn(2, 0, 1'b0, 1);
        run_txn(2, 0, 1'b0, 2);
        run_txn(6, 1, 1'b1, 0);

        // load with a simultaneous start must not begin a transaction
        load_stock = 1'b1;
        start      = 1'b1;
        dime_in    = CW'(0);
        nickel_in  = CW'(5);
        credit     = CW'(1);
        price      = CW'(0);
        tick();
        load_stock = 1'b0;
        start      = 1'b0;
        md = 0;
        mn = 5;
        check("load_start_busy", 32'(busy), 0);
        check_stock("load_start");

        credit = CW'(1);
        price  = CW'(0);
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_nickel", 32'(hop_nickel), 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_nickel", 32'(hop_nickel), 0);
        check("async_rst_busy", 32'(busy), 0);
        md = 0;
        mn = 0;
        check_stock("async_rst");
        #1 reset = 1'b0;
        tick();

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 2) == 0) do_load($urandom_range(0, 15), $urandom_range(0, 15));
            run_txn($urandom_range(0, 15), $urandom_range(0, 15), 1'b0, 3);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
